// File: rtl/echo_request_input_if.sv
`default_nettype none
// echo_request_input_if: host request words in, core say() RDY/ENA out, plus
// the message-size query and malformed-header counter of the Echo request demarshaller.
interface echo_request_input_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      req_enq_v;
  logic             EN_req_enq;
  logic             RDY_req_enq;
  logic [31:0]      say_v;
  logic             say__ENA;
  logic             say__RDY;
  logic [15:0]      messageSize_size_methodNumber;
  logic [15:0]      messageSize_size;
  logic             RDY_messageSize_size;
  logic [CNT_W-1:0] err_count;
  logic             err_clear;

  modport slave (
    input  req_enq_v, EN_req_enq, say__RDY, messageSize_size_methodNumber, err_clear,
    output RDY_req_enq, say_v, say__ENA, messageSize_size, RDY_messageSize_size, err_count
  );

  modport master (
    output req_enq_v, EN_req_enq, say__RDY, messageSize_size_methodNumber, err_clear,
    input  RDY_req_enq, say_v, say__ENA, messageSize_size, RDY_messageSize_size, err_count
  );
endinterface
`default_nettype wire

// File: rtl/echo_request_input.sv
`default_nettype none
// echo_request_input: decodes Echo portal request messages and queues say()
// arguments in a small FIFO drained through the core's RDY/ENA handshake.
module echo_request_input #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  echo_request_input_if.slave  bus
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t           state;
  logic [15:0]      disc_cnt;
  logic [31:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [CNT_W-1:0] err_cnt;

  logic        fifo_full;
  logic        fifo_empty;
  logic        rdy;
  logic        accept;
  logic        enq;
  logic        deq;
  logic        hdr_valid;
  logic        malformed;
  logic [15:0] hdr_method;
  logic [15:0] hdr_len;

  // A zero length field is treated as a header-only message.
  assign hdr_method = bus.req_enq_v[31:16];
  assign hdr_len    = (bus.req_enq_v[15:0] == 16'd0) ? 16'd1 : bus.req_enq_v[15:0];
  assign hdr_valid  = (hdr_method == 16'd0) && (hdr_len == 16'd2);

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);

  // Ready uses the registered count only: a dequeue this cycle does not make room now.
  assign rdy       = (state != PAYLOAD) || !fifo_full;
  assign accept    = bus.EN_req_enq && rdy;
  assign enq       = accept && (state == PAYLOAD);
  assign deq       = !fifo_empty && bus.say__RDY;
  assign malformed = accept && (state == HDR) && !hdr_valid;

  assign bus.RDY_req_enq          = rdy;
  assign bus.say__ENA             = deq;
  assign bus.say_v                = fifo_empty ? 32'd0 : mem[rd_ptr];
  assign bus.err_count            = err_cnt;
  assign bus.RDY_messageSize_size = 1'b1;
  assign bus.messageSize_size     = (bus.messageSize_size_methodNumber == 16'd0) ? 16'd32 : 16'd0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= HDR;
      disc_cnt <= 16'd0;
    end else if (accept) begin
      case (state)
        HDR: begin
          if (hdr_valid) begin
            state <= PAYLOAD;
          end else if (hdr_len > 16'd1) begin
            state    <= DISCARD;
            disc_cnt <= hdr_len - 16'd1;
          end
        end
        PAYLOAD: state <= HDR;
        DISCARD: begin
          if (disc_cnt == 16'd1) begin
            state <= HDR;
          end
          disc_cnt <= disc_cnt - 16'd1;
        end
        default: state <= HDR;
      endcase
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      mem[wr_ptr] <= bus.req_enq_v;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_cnt <= '0;
    end else if (bus.err_clear) begin
      err_cnt <= '0;
    end else if (malformed && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_echo_request_input.sv
`default_nettype none
// tb_echo_request_input: directed and random request traffic checked against a
// message-level reference model (expected say() queue, words left, error tally).
module tb_echo_request_input;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  echo_request_input_if #(.CNT_W(CNT_W)) bus ();

  echo_request_input #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_said = 0;
  logic [31:0] m_q[$];
  int          m_left = 0;
  bit          m_in_payload = 0;
  int          m_err = 0;
  bit          clr = 0;
  bit          last_acc = 0;
  logic [15:0] qm = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Message-level view of one accepted word; returns 1 for a malformed header.
  function automatic bit model_accept(input logic [31:0] w);
    int len;
    bit bad = 0;
    if (m_left == 0) begin
      len          = (w[15:0] == 16'd0) ? 1 : int'(w[15:0]);
      m_in_payload = (w[31:16] == 16'd0) && (len == 2);
      bad          = !m_in_payload;
      m_left       = len - 1;
    end else begin
      if (m_in_payload) m_q.push_back(w);
      m_left--;
      if (m_left == 0) m_in_payload = 0;
    end
    return bad;
  endfunction

  task automatic tick(input logic en, input logic [31:0] w, input logic srdy);
    bit exp_rdy;
    bit exp_ena;
    bit bad;
    @(negedge clk);
    bus.EN_req_enq = en;
    bus.req_enq_v  = w;
    bus.say__RDY   = srdy;
    bus.err_clear  = clr;
    bus.messageSize_size_methodNumber = qm;
    #1;
    exp_rdy = !(m_in_payload && (m_left > 0) && (m_q.size() == DEPTH));
    exp_ena = (m_q.size() != 0) && srdy;
    chk("rdy_req_enq", 32'(bus.RDY_req_enq), 32'(exp_rdy));
    chk("say_ena", 32'(bus.say__ENA), 32'(exp_ena));
    chk("say_v", bus.say_v, (m_q.size() != 0) ? m_q[0] : 32'd0);
    chk("err_count", 32'(bus.err_count), 32'(m_err));
    chk("msg_size", 32'(bus.messageSize_size), (qm == 16'd0) ? 32'd32 : 32'd0);
    chk("rdy_msg_size", 32'(bus.RDY_messageSize_size), 32'd1);
    if (exp_ena) begin
      void'(m_q.pop_front());
      n_said++;
    end
    last_acc = en && exp_rdy;
    bad = last_acc ? model_accept(w) : 1'b0;
    if (clr) m_err = 0;
    else if (bad && m_err < (2**CNT_W - 1)) m_err++;
  endtask

  task automatic send(input logic [31:0] w, input logic srdy);
    for (int i = 0; i < 50; i++) begin
      tick(1'b1, w, srdy);
      if (last_acc) return;
    end
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && m_q.size() != 0; i++) tick(1'b0, 32'd0, 1'b1);
    chk("drained", 32'(m_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.EN_req_enq = 1'b0;
    #1;
    chk("rst_rdy", 32'(bus.RDY_req_enq), 32'd1);
    chk("rst_ena", 32'(bus.say__ENA), 32'd0);
    chk("rst_say_v", bus.say_v, 32'd0);
    chk("rst_err", 32'(bus.err_count), 32'd0);
    m_q.delete();
    m_left = 0;
    m_in_payload = 0;
    m_err = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int said0;
    logic [31:0] w;
    bus.EN_req_enq = 1'b0;
    bus.req_enq_v  = 32'd0;
    bus.say__RDY   = 1'b0;
    bus.err_clear  = 1'b0;
    bus.messageSize_size_methodNumber = 16'd0;
    do_reset();

    // Single say round trip.
    send(32'h0000_0002, 1'b1);
    send(32'hDEAD_BEEF, 1'b1);
    tick(1'b0, 32'd0, 1'b1);
    chk("t1_said", 32'(n_said), 32'd1);
    tick(1'b0, 32'd0, 1'b1);

    // Backpressure: FIFO fills, violating enqueues ignored, then ordered drain.
    for (int k = 1; k <= 4; k++) begin
      send(32'h0000_0002, 1'b0);
      send(32'(k), 1'b0);
    end
    send(32'h0000_0002, 1'b0);
    tick(1'b1, 32'd5, 1'b0);
    tick(1'b1, 32'd5, 1'b0);
    chk("t2_full_rdy", 32'(bus.RDY_req_enq), 32'd0);
    send(32'd5, 1'b1);
    drain();
    chk("t2_said", 32'(n_said), 32'd6);

    // Malformed long header discarded, then a valid message.
    said0 = n_said;
    send(32'h0007_0004, 1'b1);
    for (int k = 0; k < 3; k++) send(32'hBAD0_0000 + 32'(k), 1'b1);
    tick(1'b0, 32'd0, 1'b1);
    chk("t3_err", 32'(bus.err_count), 32'd1);
    chk("t3_no_say", 32'(n_said - said0), 32'd0);
    send(32'h0000_0002, 1'b1);
    send(32'h1234_5678, 1'b1);
    drain();

    // Short malformed headers and clear priority.
    send(32'h0000_0001, 1'b1);
    send(32'h0000_0000, 1'b1);
    tick(1'b0, 32'd0, 1'b1);
    chk("t4_err", 32'(bus.err_count), 32'd3);
    clr = 1'b1;
    send(32'h0000_0001, 1'b1);
    clr = 1'b0;
    tick(1'b0, 32'd0, 1'b1);
    chk("t4_clr", 32'(bus.err_count), 32'd0);

    // Reset between header and payload.
    send(32'h0000_0002, 1'b1);
    do_reset();
    send(32'h0000_0002, 1'b1);
    send(32'hA5A5_A5A5, 1'b1);
    drain();

    // Message-size query.
    qm = 16'd0;
    tick(1'b0, 32'd0, 1'b1);
    qm = 16'd3;
    tick(1'b0, 32'd0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if (m_left == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    w = 32'h0000_0002;
          default: w = {16'($urandom_range(0, 3)), 16'($urandom_range(0, 4))};
        endcase
      end else begin
        w = $urandom;
      end
      clr = ($urandom_range(0, 19) == 0);
      qm  = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom);
      tick(($urandom_range(0, 3) != 0), w, ($urandom_range(0, 3) != 0));
    end
    clr = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
